// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sweep controller: default
// parameter values, bin index width for the default size, and the
// controller state encoding.
package sdft_pkg;

    localparam int WORD_WIDTH_DEF       = 16;
    localparam int FFT_SIZE_DEF         = 512;
    localparam int MULTIPLIER_DELAY_DEF = 3;
    localparam int HOP_DEF              = 128;
    localparam int IDX_W                = $clog2(FFT_SIZE_DEF);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        FETCH = 3'd2,
        SWEEP = 3'd3,
        DRAIN = 3'd4
    } sdft_state_t;

endpackage

// File: rtl/sdft_sample_ring.sv
// Sample history ring for the sliding DFT. One write port that is either
// the zero-fill port (used while the controller initialises) or the
// pointer write that stores the newest sample and advances the pointer.
// The read port always looks at the pointer, so the oldest sample is
// available one cycle after the pointer settles.
module sdft_sample_ring #(
    parameter int  WORD_WIDTH = 16,
    parameter int  DEPTH      = 512,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_we,
    input  logic [ADDR_W-1:0]            clr_addr,
    input  logic                         push,
    input  logic signed [WORD_WIDTH-1:0] wr_data,
    output logic signed [WORD_WIDTH-1:0] rd_data
);

    logic signed [WORD_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]            ptr_r;
    logic signed [WORD_WIDTH-1:0] rd_data_r;

    // Storage writes: zero-fill during init has priority over a sample push
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_r[clr_addr] <= {WORD_WIDTH{1'b0}};
        end else if (push) begin
            mem_r[ptr_r] <= wr_data;
        end else begin
            mem_r[ptr_r] <= mem_r[ptr_r];
        end
    end

    // Pointer advance on push (wraps naturally at DEPTH) and registered read of the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r     <= {ADDR_W{1'b0}};
            rd_data_r <= {WORD_WIDTH{1'b0}};
        end else begin
            if (push) begin
                ptr_r <= ptr_r + 1'b1;
            end else begin
                ptr_r <= ptr_r;
            end
            rd_data_r <= mem_r[ptr_r];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sdft_sweep_ctrl.sv
// Sliding-DFT sweep controller: accepts one sample per pass, forms
// x_new - x_oldest, sweeps every bin through the bin RAM / twiddle ROM /
// SPU path, drains the SPU pipeline and flags a spectrum update every HOP
// samples. Build option SDFT_SAT_DIFF_EN makes the difference saturate
// instead of wrapping.
module sdft_sweep_ctrl
    import sdft_pkg::*;
#(
    parameter int  WORD_WIDTH       = WORD_WIDTH_DEF,
    parameter int  FFT_SIZE         = FFT_SIZE_DEF,
    parameter int  MULTIPLIER_DELAY = MULTIPLIER_DELAY_DEF,
    parameter int  HOP              = HOP_DEF,
    localparam int ADDR_W           = $clog2(FFT_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [WORD_WIDTH-1:0] s_data,
    output logic [ADDR_W-1:0]            bin_rd_addr,
    output logic                         bin_clr_we,
    output logic [ADDR_W-1:0]            bin_clr_addr,
    output logic signed [WORD_WIDTH-1:0] spu_sample_diff,
    output logic [ADDR_W-1:0]            spu_idx,
    output logic                         spu_wr_en,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DRN_W = $clog2(MULTIPLIER_DELAY + 2);
    localparam int HOP_W = $clog2(HOP + 1);

    localparam logic [CNT_W-1:0]  CLR_END  = CNT_W'(FFT_SIZE);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(FFT_SIZE - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(MULTIPLIER_DELAY);
    localparam logic [HOP_W-1:0]  HOP_LAST = HOP_W'(HOP - 1);

    // New minus oldest at one extra bit, then wrap or clamp back to WORD_WIDTH
    function automatic logic [WORD_WIDTH-1:0] sample_diff_fn(
        input logic [WORD_WIDTH-1:0] x_new,
        input logic [WORD_WIDTH-1:0] x_old
    );
        logic [WORD_WIDTH:0] wide;
        wide = {x_new[WORD_WIDTH-1], x_new} - {x_old[WORD_WIDTH-1], x_old};
`ifdef SDFT_SAT_DIFF_EN
        if (wide[WORD_WIDTH] != wide[WORD_WIDTH-1]) begin
            if (wide[WORD_WIDTH]) begin
                return {1'b1, {(WORD_WIDTH-1){1'b0}}};
            end else begin
                return {1'b0, {(WORD_WIDTH-1){1'b1}}};
            end
        end else begin
            return wide[WORD_WIDTH-1:0];
        end
`else
        return wide[WORD_WIDTH-1:0];
`endif
    endfunction

    sdft_state_t                  state_r;
    logic [CNT_W-1:0]             clr_cnt_r;
    logic [ADDR_W-1:0]            k_r;
    logic [DRN_W-1:0]             drain_cnt_r;
    logic [HOP_W-1:0]             hop_cnt_r;
    logic signed [WORD_WIDTH-1:0] new_r;

    logic                         s_ready_r;
    logic [ADDR_W-1:0]            bin_rd_addr_r;
    logic                         bin_clr_we_r;
    logic [ADDR_W-1:0]            bin_clr_addr_r;
    logic signed [WORD_WIDTH-1:0] diff_r;
    logic [ADDR_W-1:0]            spu_idx_r;
    logic                         spu_wr_en_r;
    logic                         busy_r;
    logic                         frame_done_r;

    logic                         ring_push_s;
    logic signed [WORD_WIDTH-1:0] ring_rd_data_s;

    // The new sample goes into the ring in the first sweep cycle, right after the oldest was read
    assign ring_push_s = (state_r == SWEEP) && (k_r == {ADDR_W{1'b0}});

    sdft_sample_ring #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (FFT_SIZE)
    ) u_ring (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_we   (bin_clr_we_r),
        .clr_addr (bin_clr_addr_r),
        .push     (ring_push_s),
        .wr_data  (new_r),
        .rd_data  (ring_rd_data_s)
    );

    // Pass sequencer: INIT clear, sample handshake, bin sweep, SPU drain and hop accounting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= INIT;
            clr_cnt_r      <= {CNT_W{1'b0}};
            k_r            <= {ADDR_W{1'b0}};
            drain_cnt_r    <= {DRN_W{1'b0}};
            hop_cnt_r      <= {HOP_W{1'b0}};
            new_r          <= {WORD_WIDTH{1'b0}};
            s_ready_r      <= 1'b0;
            bin_rd_addr_r  <= {ADDR_W{1'b0}};
            bin_clr_we_r   <= 1'b0;
            bin_clr_addr_r <= {ADDR_W{1'b0}};
            diff_r         <= {WORD_WIDTH{1'b0}};
            spu_idx_r      <= {ADDR_W{1'b0}};
            spu_wr_en_r    <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // SPU strobe and index trail the bin RAM address by one cycle to meet the read data
            spu_wr_en_r  <= (state_r == SWEEP);
            spu_idx_r    <= k_r;

            case (state_r)
                INIT: begin
                    if (clr_cnt_r == CLR_END) begin
                        bin_clr_we_r <= 1'b0;
                        s_ready_r    <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        bin_clr_we_r   <= 1'b1;
                        bin_clr_addr_r <= clr_cnt_r[ADDR_W-1:0];
                        clr_cnt_r      <= clr_cnt_r + 1'b1;
                        busy_r         <= 1'b1;
                    end
                end
                IDLE: begin
                    if (s_valid && s_ready_r) begin
                        new_r     <= s_data;
                        s_ready_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    diff_r        <= sample_diff_fn(new_r, ring_rd_data_s);
                    k_r           <= {ADDR_W{1'b0}};
                    bin_rd_addr_r <= {ADDR_W{1'b0}};
                    state_r       <= SWEEP;
                end
                SWEEP: begin
                    if (k_r == K_LAST) begin
                        drain_cnt_r <= {DRN_W{1'b0}};
                        state_r     <= DRAIN;
                    end else begin
                        k_r           <= k_r + 1'b1;
                        bin_rd_addr_r <= k_r + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DRN_LAST) begin
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                        if (hop_cnt_r == HOP_LAST) begin
                            hop_cnt_r    <= {HOP_W{1'b0}};
                            frame_done_r <= 1'b1;
                        end else begin
                            hop_cnt_r <= hop_cnt_r + 1'b1;
                        end
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 1'b1;
                    end
                end
                default: begin
                    clr_cnt_r    <= {CNT_W{1'b0}};
                    bin_clr_we_r <= 1'b0;
                    s_ready_r    <= 1'b0;
                    busy_r       <= 1'b1;
                    state_r      <= INIT;
                end
            endcase
        end
    end

    assign s_ready         = s_ready_r;
    assign bin_rd_addr     = bin_rd_addr_r;
    assign bin_clr_we      = bin_clr_we_r;
    assign bin_clr_addr    = bin_clr_addr_r;
    assign spu_sample_diff = diff_r;
    assign spu_idx         = spu_idx_r;
    assign spu_wr_en       = spu_wr_en_r;
    assign busy            = busy_r;
    assign frame_done      = frame_done_r;

endmodule

// File: tb/tb_sdft_sweep_ctrl.sv
// Directed bench for sdft_sweep_ctrl with FFT_SIZE = 8, MULTIPLIER_DELAY = 3,
// HOP = 4. Cycle numbers are relative to the handshake cycle (cycle 0);
// outputs are sampled on the falling edge.
module tb_sdft_sweep_ctrl;

    localparam int W    = 16;
    localparam int N    = 8;
    localparam int D    = 3;
    localparam int H    = 4;
    localparam int LAST = N + 3 + D;

    logic          clk;
    logic          reset_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic [2:0]    bin_rd_addr;
    logic          bin_clr_we;
    logic [2:0]    bin_clr_addr;
    logic [W-1:0]  spu_sample_diff;
    logic [2:0]    spu_idx;
    logic          spu_wr_en;
    logic          busy;
    logic          frame_done;

    int n_vec;
    int n_miscompare;
    int fd_count;
    int fd_before;

    sdft_sweep_ctrl #(
        .WORD_WIDTH       (W),
        .FFT_SIZE         (N),
        .MULTIPLIER_DELAY (D),
        .HOP              (H)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .bin_rd_addr     (bin_rd_addr),
        .bin_clr_we      (bin_clr_we),
        .bin_clr_addr    (bin_clr_addr),
        .spu_sample_diff (spu_sample_diff),
        .spu_idx         (spu_idx),
        .spu_wr_en       (spu_wr_en),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses seen while out of reset
    always @(negedge clk) begin
        if (reset_n && frame_done) fd_count <= fd_count + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold reset, check reset outputs, release and check the INIT clear sequence
    task automatic do_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        repeat (2) @(negedge clk);
        check_vec("rst_ctrl_outs", {27'd0, s_ready, busy, bin_clr_we, spu_wr_en, frame_done}, 32'd0);
        check_vec("rst_diff", {16'd0, spu_sample_diff}, 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            check_vec($sformatf("init_clr_we_c%0d", k), {31'd0, bin_clr_we}, 32'd1);
            check_vec($sformatf("init_clr_addr_c%0d", k), {29'd0, bin_clr_addr}, k - 1);
            check_vec($sformatf("init_ready_c%0d", k), {30'd0, s_ready, busy}, 32'd1);
        end
        @(negedge clk);
        check_vec("init_done_ready", {30'd0, s_ready, bin_clr_we}, 32'd2);
        check_vec("init_done_busy", {31'd0, busy}, 32'd0);
    endtask

    // Wait for s_ready (bounded), hand over one sample and follow the pass to its first IDLE cycle
    task automatic do_pass(input logic [W-1:0] sample, input logic [W-1:0] exp_diff,
                           input logic exp_fd, input bit detail);
        int wait_cyc;
        wait_cyc = 0;
        while (s_ready !== 1'b1 && wait_cyc < 64) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_vec("pass_ready_wait", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = sample;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 1; c <= LAST; c++) begin
            if (c == 2) check_vec($sformatf("diff_%0h", sample), {16'd0, spu_sample_diff}, {16'd0, exp_diff});
            if (detail) begin
                check_vec($sformatf("wr_en_c%0d", c), {31'd0, spu_wr_en}, (c >= 3 && c <= N + 2) ? 32'd1 : 32'd0);
                if (c >= 3 && c <= N + 2) check_vec($sformatf("spu_idx_c%0d", c), {29'd0, spu_idx}, c - 3);
                if (c >= 2 && c <= N + 1) check_vec($sformatf("rd_addr_c%0d", c), {29'd0, bin_rd_addr}, c - 2);
                check_vec($sformatf("ready_busy_c%0d", c), {30'd0, s_ready, busy}, (c == LAST) ? 32'd2 : 32'd1);
                if (c == LAST - 1) check_vec("diff_held", {16'd0, spu_sample_diff}, {16'd0, exp_diff});
            end
            if (c == LAST) begin
                check_vec($sformatf("end_ready_%0h", sample), {31'd0, s_ready}, 32'd1);
                check_vec($sformatf("frame_done_%0h", sample), {31'd0, frame_done}, {31'd0, exp_fd});
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        fd_count     = 0;
        reset_n      = 1'b0;
        s_valid      = 1'b0;
        s_data       = 16'h0000;

        // Reset, INIT and one fully timed pass on a zeroed ring
        do_reset();
        do_pass(16'd100, 16'd100, 1'b0, 1'b1);

        // Abort in the middle of the sweep at k = 3
        fd_before = fd_count;
        s_valid = 1'b1;
        s_data  = 16'd77;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_vec("abort_k", {29'd0, bin_rd_addr}, 32'd3);
        check_vec("abort_wr_en_before", {31'd0, spu_wr_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_vec("abort_wr_en_after", {31'd0, spu_wr_en}, 32'd0);
        check_vec("abort_busy_after", {31'd0, busy}, 32'd0);
        do_reset();
        do_pass(16'd42, 16'd42, 1'b0, 1'b0);
        #1;
        check_vec("abort_no_frame", fd_count, fd_before);

        // Ring wrap and hop pulses: samples 1..9
        do_reset();
        fd_before = fd_count;
        for (int i = 1; i <= N; i++) begin
            do_pass(W'(i), W'(i), (i % H) == 0, 1'b0);
        end
        do_pass(16'd9, 16'd8, 1'b0, 1'b0);
        #1;
        check_vec("frame_pulses", fd_count - fd_before, 32'd2);

        // Extreme difference: old 0x8000, new 0x7FFF
        do_reset();
        do_pass(16'h8000, 16'h8000, 1'b0, 1'b0);
        for (int i = 2; i <= N; i++) begin
            do_pass(16'h0000, 16'h0000, (i % H) == 0, 1'b0);
        end
`ifdef SDFT_SAT_DIFF_EN
        do_pass(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
`else
        do_pass(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

    // Run-away guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdft_sweep_ctrl.md
Name: sdft_sweep_ctrl

Overview:
- Sequences one sliding-DFT update pass per accepted input sample.
- Keeps the last FFT_SIZE samples in a ring, forms sample_diff = x_new − x_oldest, and sweeps bin index k = 0..FFT_SIZE-1 through the bin RAM, twiddle ROM and SPU datapath.
- Drains the SPU pipeline, then signals a spectrum update every HOP samples.
- Sits between the ADC sample stream and the SPU / bin RAM pair.

Parameters:
- WORD_WIDTH, 16: sample and per-component bin width.
- FFT_SIZE, 512: number of bins and ring depth; power of two, ≥ 8.
- MULTIPLIER_DELAY, 3: SPU latency in cycles, from i_idx/wr_en to o_idx/o_wr_en.
- HOP, 128: samples per frame_done pulse; 1..FFT_SIZE.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_data  in  WORD_WIDTH  signed input sample
- bin_rd_addr  out  log2(FFT_SIZE)  bin RAM read address; also the twiddle ROM address (both 1-cycle synchronous read)
- bin_clr_we  out  1  bin RAM write-zero strobe (INIT only)
- bin_clr_addr  out  log2(FFT_SIZE)  bin RAM clear address
- spu_sample_diff  out  WORD_WIDTH  signed difference to SPU
- spu_idx  out  log2(FFT_SIZE)  SPU i_idx
- spu_wr_en  out  1  SPU wr_en
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse: spectrum consistent after HOP samples

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): all outputs 0, state INIT, ring pointer 0, hop count 0.
- States: INIT → IDLE → FETCH → SWEEP → DRAIN → IDLE.
- INIT:
  - Counter c = 0..FFT_SIZE-1 writes zero to ring[c].
  - Same cycle: bin_clr_we = 1, bin_clr_addr = c.
  - After c = FFT_SIZE-1, go to IDLE. s_ready = 0 throughout.
- IDLE: s_ready = 1. On s_valid & s_ready (cycle 0), latch s_data and go to FETCH. s_ready = 0 in all other states.
- Timing of one pass, relative to handshake cycle 0, N = FFT_SIZE:
  - Cycle 1 FETCH: ring read address = ptr.
  - Cycle 2: old sample available. spu_sample_diff = new − old, held constant until the pass ends. Ring write ring[ptr] = new. ptr increments mod N.
  - Cycles 2..N+1 SWEEP: bin_rd_addr = cycle − 2.
  - Cycles 3..N+2: spu_idx and spu_wr_en = 1, delayed one cycle to align with the RAM/ROM read data. spu_wr_en = 0 at all other times.
  - Cycles N+2..N+2+MULTIPLIER_DELAY: DRAIN. The last SPU write occurs at cycle N+2+MULTIPLIER_DELAY.
  - Cycle N+3+MULTIPLIER_DELAY: IDLE.
  - Accepted-sample throughput = one per N+3+MULTIPLIER_DELAY cycles.
- Hop counter increments at DRAIN exit. When it reaches HOP, frame_done pulses in the first IDLE cycle and the counter returns to 0.
- Arithmetic: difference computed at WORD_WIDTH+1 bits, then truncated to WORD_WIDTH (two's-complement wrap).
- s_valid while busy: ignored, sample not consumed; the source must hold it.
- reset_n low mid-pass: immediate abort, return to INIT. Ring and bins are re-zeroed and no partial frame_done is produced.
- Ring wrap: ptr rolls from N-1 to 0 with no bubble.

Optional Feature:
- SDFT_SAT_DIFF_EN defined: the difference saturates to [−2^(W−1), 2^(W−1)−1].
- Undefined: wrap-around truncation as above.

Decomposition:
- Package sdft_pkg: IDX_W = $clog2(FFT_SIZE), state enum {INIT, IDLE, FETCH, SWEEP, DRAIN}, MULTIPLIER_DELAY default.
- Sub-module sdft_sample_ring: FFT_SIZE×WORD_WIDTH single-port-read / single-port-write RAM with pointer, zero-fill port and 1-cycle read.

Test Plan:
- Reset release, FFT_SIZE = 8 → bin_clr_we high 8 cycles with addrs 0..7; s_ready rises at cycle 9.
- Sample 100 accepted after INIT → spu_sample_diff = 100. spu_idx 0..7 with spu_wr_en on cycles 3..10. Next s_ready at cycle 14 (N=8, D=3).
- Feed 9 samples 1..9 (N=8) → 9th pass diff = 9 − 1 = 8, showing the ring wrapped.
- s_data = 0x7FFF after old = 0x8000 → wrap build gives diff 0xFFFF; SDFT_SAT_DIFF_EN build gives 0x7FFF.
- HOP = 4: feed 8 samples → exactly two frame_done pulses, each in the first IDLE cycle after passes 4 and 8.
- Drop reset_n at SWEEP k = 3 → spu_wr_en = 0 the same cycle; INIT re-runs; the first new-sample diff equals the sample value.
